// File: rtl/fft_frame_sequencer_if.sv
// fft_frame_sequencer_if: upstream sample stream and downstream bin stream
interface fft_frame_sequencer_if #(
    parameter int DW = 16
);
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_real;
    logic [DW-1:0] s_imag;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_real;
    logic [DW-1:0] m_imag;
    logic [4:0]    m_index;
    logic          m_last;
    modport master (
        output s_valid, s_real, s_imag, m_ready,
        input  s_ready, m_valid, m_real, m_imag, m_index, m_last
    );
    modport slave (
        input  s_valid, s_real, s_imag, m_ready,
        output s_ready, m_valid, m_real, m_imag, m_index, m_last
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: buffers a frame, feeds the FFT core, captures and drains its bins
module fft_frame_sequencer #(
    parameter int DW      = 16,
    parameter int N       = 32,
    parameter int TIMEOUT = 1023,
    parameter int CAP_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    fft_frame_sequencer_if.slave  bus,
    output logic                  fft_rst_o,
    output logic [DW-1:0]         fft_real_o,
    output logic [DW-1:0]         fft_imag_o,
    input  logic                  fft_done_i,
    input  logic [DW-1:0]         fft_real_i,
    input  logic [DW-1:0]         fft_imag_i,
    output logic                  busy_o,
    output logic                  err_o,
    output logic [15:0]           frames_o
);
    localparam int CW = $clog2(TIMEOUT + N + CAP_LAT + 1);
    typedef enum logic [2:0] {FILL, LOAD, WAIT, CAPTURE, DRAIN} state_t;
    state_t          state_q;
    logic [5:0]      in_count_q, in_count_d;
    logic [4:0]      out_idx_q;
    logic [CW-1:0]   cnt_q, cap_full;
    logic            err_q;
    logic [15:0]     frames_q;
    logic [2*DW-1:0] inbuf  [N];
    logic [2*DW-1:0] outbuf [N];
    logic            accept, take, cap_we;
    assign bus.s_ready = state_q != LOAD && in_count_q < 6'(N);
    assign accept      = bus.s_valid && bus.s_ready;
    assign take        = bus.m_valid && bus.m_ready;
    assign in_count_d  = (state_q == LOAD && cnt_q == CW'(N - 1)) ? 6'd0 : in_count_q + 6'(accept);
    // cnt_q below CAP_LAT-1 wraps to a huge index, which suppresses the write
    assign cap_full    = cnt_q - CW'(CAP_LAT - 1);
    assign cap_we      = state_q == CAPTURE && cap_full < CW'(N);
    assign fft_rst_o   = !(state_q inside {LOAD, WAIT, CAPTURE});
    assign {fft_real_o, fft_imag_o} = state_q == LOAD ? inbuf[cnt_q[4:0]] : '0;
    assign bus.m_valid = state_q == DRAIN;
    assign {bus.m_real, bus.m_imag} = outbuf[out_idx_q];
    assign bus.m_index = out_idx_q;
    assign bus.m_last  = state_q == DRAIN && &out_idx_q;
    assign busy_o      = state_q != FILL;
    assign err_o       = err_q;
    assign frames_o    = frames_q;

    // frame buffers: upstream writes the input frame, core outputs fill the output frame
    always_ff @(posedge clk) begin
        if (accept) inbuf[in_count_q[4:0]] <= {bus.s_real, bus.s_imag};
        if (cap_we) outbuf[cap_full[4:0]] <= {fft_real_i, fft_imag_i};
    end

    // frame sequencing: fill, load the core, wait for done, capture, drain
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FILL;
            in_count_q <= '0;
            out_idx_q  <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            frames_q   <= '0;
        end else begin
            in_count_q <= in_count_d;
            err_q      <= 1'b0;
            cnt_q      <= cnt_q + 1'b1;
            case (state_q)
                FILL: if (in_count_q == 6'(N)) begin
                    state_q <= LOAD;
                    cnt_q   <= '0;
                end
                LOAD: if (cnt_q == CW'(N - 1)) begin
                    state_q <= WAIT;
                    cnt_q   <= '0;
                end
                WAIT: if (fft_done_i) begin
                    state_q <= CAPTURE;
                    cnt_q   <= '0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_q   <= FILL;
                    err_q     <= 1'b1;
                    out_idx_q <= '0;
                end
                CAPTURE: if (cnt_q == CW'(N + CAP_LAT - 2)) state_q <= DRAIN;
                DRAIN: if (take) begin
                    out_idx_q <= out_idx_q + 5'd1;
                    if (&out_idx_q) begin
                        frames_q <= frames_q + 16'd1;
                        state_q  <= in_count_q == 6'(N) ? LOAD : FILL;
                        cnt_q    <= '0;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: directed table-driven bench with a simple FFT core stub
module tb_fft_frame_sequencer;
    logic        clk = 0, reset = 1;
    logic        fft_rst, fft_done, busy, err;
    logic [15:0] fft_real_o, fft_imag_o, fft_re, fft_im, frames;
    int          n_checks = 0, n_fail = 0;
    int          c = 0;
    bit          stub_en = 1;

    typedef struct {
        logic [15:0] in_re, in_im, in2_re, in2_im, bin_re, bin_im;
    } vec_t;
    vec_t tab [32];

    fft_frame_sequencer_if #(.DW(16)) bus ();

    fft_frame_sequencer #(.DW(16), .N(32), .TIMEOUT(64), .CAP_LAT(1)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .fft_rst_o(fft_rst), .fft_real_o(fft_real_o), .fft_imag_o(fft_imag_o),
        .fft_done_i(fft_done), .fft_real_i(fft_re), .fft_imag_i(fft_im),
        .busy_o(busy), .err_o(err), .frames_o(frames)
    );

    always #5 clk = ~clk;

    // core stub: done 20 cycles into WAIT (cycle 52 after release), bin k at cycle 53+k
    always @(negedge clk) begin
        c = fft_rst ? -1 : c + 1;
        fft_done = stub_en && c >= 52;
        fft_re = 16'(100 + c - 53);
        fft_im = 16'(-(100 + c - 53));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] re, input logic [15:0] im);
        int t = 0;
        bus.s_valid = 1; bus.s_real = re; bus.s_imag = im;
        while (!bus.s_ready && t < 200) begin @(negedge clk); t++; end
        check("push_ready", bus.s_ready, 1);
        @(negedge clk);
        bus.s_valid = 0;
    endtask

    task automatic push_frame(input bit second);
        for (int k = 0; k < 32; k++)
            push(second ? tab[k].in2_re : tab[k].in_re, second ? tab[k].in2_im : tab[k].in_im);
    endtask

    task automatic fill_done();
        check("armed_rst", fft_rst, 1);
        check("armed_ready", bus.s_ready, 0);
        @(negedge clk);
    endtask

    task automatic load_check(input bit second);
        for (int k = 0; k < 32; k++) begin
            check($sformatf("load_re[%0d]", k), fft_real_o, second ? tab[k].in2_re : tab[k].in_re);
            check($sformatf("load_im[%0d]", k), fft_imag_o, second ? tab[k].in2_im : tab[k].in_im);
            check($sformatf("load_ready[%0d]", k), bus.s_ready, 0);
            check($sformatf("load_rst[%0d]", k), fft_rst, 0);
            @(negedge clk);
        end
    endtask

    task automatic wait_load();
        int t = 0;
        while (fft_rst && t < 100) begin @(negedge clk); t++; end
        check("load_start", fft_rst, 0);
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!bus.m_valid && t < 300) begin @(negedge clk); t++; end
        check("m_valid_wait", bus.m_valid, 1);
    endtask

    task automatic drain(input bit toggle);
        int idx = 0, t = 0;
        while (idx < 32 && t < 200) begin
            bus.m_ready = toggle ? (t % 2 == 0) : 1'b1;
            check($sformatf("m_valid[%0d]", idx), bus.m_valid, 1);
            check($sformatf("m_real[%0d]", idx), bus.m_real, tab[idx].bin_re);
            check($sformatf("m_imag[%0d]", idx), bus.m_imag, tab[idx].bin_im);
            check($sformatf("m_index[%0d]", idx), bus.m_index, 32'(idx));
            check($sformatf("m_last[%0d]", idx), bus.m_last, idx == 31);
            if (bus.m_ready) idx++;
            t++;
            @(negedge clk);
        end
        bus.m_ready = 0;
        check("drain_count", idx, 32);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs = 0, err_at = -1, mv = 0;
        logic err_rst = 0, err_rdy = 0;
        for (int k = 0; k < 32; k++)
            tab[k] = '{16'(k), 16'(-k), 16'(16'h0100 + k), 16'(16'h8000 | k),
                       16'(100 + k), 16'(-(100 + k))};
        bus.s_valid = 0; bus.s_real = 0; bus.s_imag = 0; bus.m_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_fft_rst", fft_rst, 1);
        check("rst_s_ready", bus.s_ready, 1);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_frames", frames, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_m_index", bus.m_index, 0);
        check("rst_m_last", bus.m_last, 0);
        check("rst_fft_real", fft_real_o, 0);
        reset = 0;
        // frame 1, then drain with a stalling sink while frame 2 streams in
        push_frame(0);
        fill_done();
        load_check(0);
        wait_valid();
        fork
            drain(1);
            push_frame(1);
        join
        check("back2back_rst", fft_rst, 0);
        check("back2back_busy", busy, 1);
        check("frames_1", frames, 1);
        load_check(1);
        wait_valid();
        drain(0);
        check("frames_2", frames, 2);
        check("idle_m_valid", bus.m_valid, 0);
        check("idle_rst", fft_rst, 1);
        // timeout: the core never reports done
        stub_en = 0;
        push_frame(0);
        wait_load();
        for (int j = 0; j < 120; j++) begin
            if (err) begin
                errs++; err_at = j; err_rst = fft_rst; err_rdy = bus.s_ready;
            end
            if (bus.m_valid) mv++;
            @(negedge clk);
        end
        check("timeout_pulses", errs, 1);
        check("timeout_cycle", err_at, 96);
        check("timeout_rst", err_rst, 1);
        check("timeout_ready", err_rdy, 1);
        check("timeout_no_valid", mv, 0);
        check("timeout_frames", frames, 2);
        // reset in the middle of LOAD
        stub_en = 1;
        push_frame(1);
        wait_load();
        repeat (10) @(negedge clk);
        check("mid_load_re10", fft_real_o, tab[10].in2_re);
        reset = 1;
        @(negedge clk);
        check("mid_rst_fft_rst", fft_rst, 1);
        check("mid_rst_ready", bus.s_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_frames", frames, 0);
        reset = 0;
        push_frame(0);
        fill_done();
        load_check(0);
        wait_valid();
        drain(0);
        check("after_rst_frames", frames, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
